// File: rtl/spart_pkg.sv
// spart_pkg: shared constants, FSM encoding and bus addresses for the SPART blocks
package spart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = OVERSAMPLE / 2 - 1;
  localparam int DATA_BITS = 8;
  localparam logic [1:0] IOADDR_DATA = 2'b00;
  localparam logic [1:0] IOADDR_STATUS = 2'b01;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
endpackage

// File: rtl/spart_rx_if.sv
// spart_rx_if: tick, serial line and received-data status bundle of the receiver
interface spart_rx_if #(parameter int DATA_BITS = spart_pkg::DATA_BITS);
  logic brg_en;
  logic rxd;
  logic clr_rda;
  logic [DATA_BITS-1:0] rx_data;
  logic rda;
  logic ferr;
  logic ovr;
  modport master (output brg_en, rxd, clr_rda, input rx_data, rda, ferr, ovr);
  modport slave (input brg_en, rxd, clr_rda, output rx_data, rda, ferr, ovr);
endinterface

// File: rtl/spart_sync2.sv
// spart_sync2: two-flop synchronizer with a parameterized reset value
module spart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;
  // shift the asynchronous input through two stages
  always_comb sync_d = {sync_q[0], d};
  // synchronizer flops, reset to the idle level
  always_ff @(posedge clk) sync_q <= rst ? {2{RST_VAL}} : sync_d;
  assign q = sync_q[1];
endmodule

// File: rtl/spart_rx.sv
// spart_rx: oversampling 8N1 serial receiver with data-available, framing and overrun flags
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = spart_pkg::OVERSAMPLE,
  parameter int DATA_BITS = spart_pkg::DATA_BITS
) (
  input logic clk,
  input logic rst,
  spart_rx_if.slave bus
);
  localparam logic [3:0] MID = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  rx_state_e state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic rda_q, rda_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic rxd_s, last_tick, load;
  spart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(bus.rxd), .q(rxd_s));
  assign last_tick = bus.brg_en && tick_q == LAST;
  assign load = state_q == STOP && last_tick;
  // state register
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  // next state: moves only on oversample ticks; start bit re-checked mid-bit to reject glitches
  always_comb begin
    state_d = state_q;
    if (bus.brg_en)
      case (state_q)
        IDLE:    state_d = rxd_s ? IDLE : START;
        START:   state_d = tick_q != MID ? START : rxd_s ? IDLE : DATA;
        DATA:    state_d = tick_q == LAST && bit_q == LAST_BIT ? STOP : DATA;
        default: state_d = tick_q == LAST ? IDLE : STOP;
      endcase
  end
  // counters, shifter and status flags; a load outranks a simultaneous clear
  always_comb begin
    tick_d = !bus.brg_en ? tick_q : (state_d != state_q || state_q == IDLE || tick_q == LAST) ? '0 : tick_q + 1'b1;
    bit_d = !bus.brg_en ? bit_q : state_q != DATA ? '0 : tick_q == LAST ? bit_q + 1'b1 : bit_q;
    shift_d = state_q == DATA && last_tick ? {rxd_s, shift_q[DATA_BITS-1:1]} : shift_q;
    rx_data_d = load ? shift_q : rx_data_q;
    rda_d = load | (rda_q & ~bus.clr_rda);
    ferr_d = load ? ~rxd_s : ferr_q & ~bus.clr_rda;
    ovr_d = load ? rda_q & ~bus.clr_rda : ovr_q & ~bus.clr_rda;
  end
  // datapath and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      rx_data_q <= '0;
      rda_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      rx_data_q <= rx_data_d;
      rda_q <= rda_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
    end
  end
  assign bus.rx_data = rx_data_q;
  assign bus.rda = rda_q;
  assign bus.ferr = ferr_q;
  assign bus.ovr = ovr_q;
endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: directed frames against spart_rx with hand-computed expectations
module tb_spart_rx;
  logic clk, rst;
  int n_cmp = 0;
  int n_fail = 0;
  int bcnt;
  logic rda_pre, rda_post;
  spart_rx_if bus ();
  spart_rx dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // brg_en: one pulse every 4 clocks, driven on the falling edge
  initial begin
    bus.brg_en = 1'b0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      bcnt++;
      bus.brg_en = (bcnt % 4 == 0);
    end
  end

  // start a frame just before a posedge carrying brg_en so load timing is exact
  task automatic align();
    do begin @(negedge clk); #1; end while (!bus.brg_en);
  endtask

  // one 64-clk-per-bit frame; load lands 612 clks after the first posedge of the start bit
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic clr_at_load);
    align();
    bus.rxd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (64) @(negedge clk);
      bus.rxd = d[i];
    end
    repeat (64) @(negedge clk);
    bus.rxd = stop;
    repeat (36) @(negedge clk);
    rda_pre = bus.rda;
    bus.clr_rda = clr_at_load;
    @(negedge clk);
    rda_post = bus.rda;
    bus.clr_rda = 1'b0;
    repeat (27) @(negedge clk);
    bus.rxd = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr_rda = 1'b1;
    @(negedge clk);
    bus.clr_rda = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=00", bus.rx_data); end
    n_cmp++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL reset_rda got=%b exp=0", bus.rda); end
    n_cmp++; if (bus.ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got=%b exp=0", bus.ferr); end
    n_cmp++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got=%b exp=0", bus.ovr); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_glitch();
    @(negedge clk);
    bus.rxd = 1'b0;
    repeat (12) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (100) @(negedge clk);
    n_cmp++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL glitch_rda got=%b exp=0", bus.rda); end
    n_cmp++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL glitch_rx_data got=%h exp=00", bus.rx_data); end
    n_cmp++; if (bus.ferr !== 1'b0) begin n_fail++; $display("FAIL glitch_ferr got=%b exp=0", bus.ferr); end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, 1'b0);
    n_cmp++; if (rda_pre !== 1'b0) begin n_fail++; $display("FAIL a5_rda_before_load got=%b exp=0", rda_pre); end
    n_cmp++; if (rda_post !== 1'b1) begin n_fail++; $display("FAIL a5_rda_after_load got=%b exp=1", rda_post); end
    n_cmp++; if (bus.rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_rx_data got=%h exp=a5", bus.rx_data); end
    n_cmp++; if (bus.ferr !== 1'b0) begin n_fail++; $display("FAIL a5_ferr got=%b exp=0", bus.ferr); end
    n_cmp++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL a5_ovr got=%b exp=0", bus.ovr); end
    pulse_clr();
    n_cmp++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL a5_clr_rda got=%b exp=0", bus.rda); end
    n_cmp++; if (bus.rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_clr_rx_data got=%h exp=a5", bus.rx_data); end
  endtask

  task automatic test_ferr();
    send_frame(8'h3C, 1'b0, 1'b0);
    n_cmp++; if (bus.rx_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_rx_data got=%h exp=3c", bus.rx_data); end
    n_cmp++; if (bus.rda !== 1'b1) begin n_fail++; $display("FAIL ferr_rda got=%b exp=1", bus.rda); end
    n_cmp++; if (bus.ferr !== 1'b1) begin n_fail++; $display("FAIL ferr_ferr got=%b exp=1", bus.ferr); end
    n_cmp++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL ferr_ovr got=%b exp=0", bus.ovr); end
    repeat (80) @(negedge clk);
    n_cmp++; if (bus.rx_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_hold_rx_data got=%h exp=3c", bus.rx_data); end
    pulse_clr();
    n_cmp++; if (bus.ferr !== 1'b0) begin n_fail++; $display("FAIL ferr_clr_ferr got=%b exp=0", bus.ferr); end
    n_cmp++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL ferr_clr_rda got=%b exp=0", bus.rda); end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 1'b0);
    n_cmp++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_first_ovr got=%b exp=0", bus.ovr); end
    send_frame(8'h22, 1'b1, 1'b0);
    n_cmp++; if (bus.rx_data !== 8'h22) begin n_fail++; $display("FAIL ovr_rx_data got=%h exp=22", bus.rx_data); end
    n_cmp++; if (bus.rda !== 1'b1) begin n_fail++; $display("FAIL ovr_rda got=%b exp=1", bus.rda); end
    n_cmp++; if (bus.ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_ovr got=%b exp=1", bus.ovr); end
    pulse_clr();
    n_cmp++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL ovr_clr_rda got=%b exp=0", bus.rda); end
    n_cmp++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clr_ovr got=%b exp=0", bus.ovr); end
    n_cmp++; if (bus.rx_data !== 8'h22) begin n_fail++; $display("FAIL ovr_clr_rx_data got=%h exp=22", bus.rx_data); end
  endtask

  task automatic test_clr_at_load();
    send_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1);
    n_cmp++; if (rda_post !== 1'b1) begin n_fail++; $display("FAIL clrload_rda got=%b exp=1", rda_post); end
    n_cmp++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL clrload_ovr got=%b exp=0", bus.ovr); end
    n_cmp++; if (bus.rx_data !== 8'h55) begin n_fail++; $display("FAIL clrload_rx_data got=%h exp=55", bus.rx_data); end
  endtask

  task automatic test_rst_mid_frame();
    logic [7:0] d;
    d = 8'h96;
    align();
    bus.rxd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (64) @(negedge clk);
      bus.rxd = d[i];
    end
    repeat (30) @(negedge clk);
    rst = 1'b1;
    bus.rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_data got=%h exp=00", bus.rx_data); end
    n_cmp++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL rstmid_rda got=%b exp=0", bus.rda); end
    n_cmp++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovr got=%b exp=0", bus.ovr); end
    repeat (100) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b0);
    n_cmp++; if (bus.rx_data !== 8'h5A) begin n_fail++; $display("FAIL rstmid_next_rx_data got=%h exp=5a", bus.rx_data); end
    n_cmp++; if (bus.rda !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_rda got=%b exp=1", bus.rda); end
    n_cmp++; if (bus.ferr !== 1'b0) begin n_fail++; $display("FAIL rstmid_next_ferr got=%b exp=0", bus.ferr); end
    n_cmp++; if (bus.ovr !== 1'b0) begin n_fail++; $display("FAIL rstmid_next_ovr got=%b exp=0", bus.ovr); end
  endtask

  initial begin
    rst = 1'b1;
    bus.rxd = 1'b1;
    bus.clr_rda = 1'b0;
    test_reset();
    test_glitch();
    test_basic();
    test_ferr();
    test_overrun();
    test_clr_at_load();
    test_rst_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, brg_en ticks per bit period.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (8N1, LSB first).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port brg_en  input  1  one-clk pulse per oversample tick from brg.
REQ-006 SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port clr_rda  input  1  one-clk pulse from bus interface on data-register read.
REQ-008 SHALL have port rx_data  output  8  last received byte.
REQ-009 SHALL have port rda  output  1  received data available.
REQ-010 SHALL have port ferr  output  1  framing error (stop bit sampled 0).
REQ-011 SHALL have port ovr  output  1  overrun (new byte loaded while rda=1).

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer (rxd_s); all sampling uses rxd_s only.
REQ-013 SHALL advance tick counter (4-bit) and FSM only in cycles with brg_en=1; with brg_en=0 all state holds.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: on brg_en with rxd_s=0 -> START, tick counter cleared to 0.
REQ-016 START: on the tick where counter = OVERSAMPLE/2-1 (7), rxd_s=0 -> DATA with counter and bit counter cleared; rxd_s=1 -> IDLE (glitch reject, nothing loaded).
REQ-017 DATA: on every tick where counter = OVERSAMPLE-1, sample rxd_s into MSB of shift register (shift right), increment 3-bit bit counter; after bit DATA_BITS-1 -> STOP.
REQ-018 STOP: on tick where counter = OVERSAMPLE-1, sample stop bit, load rx_data from shift register, ferr <= ~rxd_s, -> IDLE.
REQ-019 Latency: rx_data, rda, ferr SHALL update on the clk edge ending the brg_en cycle that samples the stop bit (visible next cycle).
REQ-020 Frame with stop bit 0 SHALL still load rx_data and set rda; ferr=1; IDLE then treats continued low as new start (break yields repeated 0x00 frames with ferr).
REQ-021 ovr SHALL be set on load when rda=1 and clr_rda=0; rx_data overwritten with new byte.
REQ-022 clr_rda SHALL clear rda, ferr, ovr on the next edge; rx_data holds until next load.
REQ-023 Simultaneous clr_rda and load: load wins, rda=1, ferr per new stop bit, ovr=0.
REQ-024 Tick and bit counters SHALL wrap modulo their width; no other arithmetic.

Reset
REQ-025 rst SHALL force FSM IDLE, counters 0, shift register 0x00, synchronizer flops 1, rx_data=0x00, rda=0, ferr=0, ovr=0 on next edge.
REQ-026 rst mid-frame SHALL discard partial data; next frame after release SHALL be received correctly.

Structure
REQ-027 Shared package spart_pkg SHALL hold FSM state encoding, OVERSAMPLE, MID_SAMPLE (7), DATA_BITS, and bus ioaddr constants (DATA=2'b00, STATUS=2'b01).
REQ-028 Synchronizer SHALL be a separate sub-module spart_sync2 (2-flop, reset value parameterized).

Verification (brg_en every 4 clk, bit = 64 clk)
REQ-029 Send 0xA5, stop=1 -> rx_data=0xA5, rda=1, ferr=0, ovr=0 one cycle after stop-bit sample tick.
REQ-030 rxd low 12 clk then high -> FSM returns IDLE at mid-start tick, rda stays 0, rx_data stays 0x00.
REQ-031 Send 0x3C with stop=0 -> rx_data=0x3C, rda=1, ferr=1.
REQ-032 Send 0x11 then 0x22, no clr_rda -> rx_data=0x22, rda=1, ovr=1; pulse clr_rda -> rda=0, ovr=0, rx_data=0x22.
REQ-033 clr_rda pulsed in load cycle of 0x55 -> rda=1, ovr=0, rx_data=0x55.
REQ-034 rst pulsed during data bit 4 -> all outputs reset next cycle; following frame 0x5A -> rx_data=0x5A, rda=1.
